// File: rtl/icache_fill_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// icache_fill_ctrl_pkg
// Shared definitions for the instruction-cache fill controller: block/beat
// geometry, the fill FSM state encoding and a saturating counter helper.
// No ports (package).
// -----------------------------------------------------------------------------
package icache_fill_ctrl_pkg;

   // Geometry of one icache block and of one DRAM response beat.
   localparam int ICACHE_DATA_BLOCK_SIZE = 64;
   localparam int ICACHE_DRAM_BEAT_BITS  = 32;
   localparam int ICACHE_FILL_BEATS      = ICACHE_DATA_BLOCK_SIZE / ICACHE_DRAM_BEAT_BITS;

   // Fill FSM states, 3-bit encoding.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_WRITE  = 3'd4,
      ST_RESUME = 3'd5
   } fill_state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] value);
      return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/icache_fill_ctrl_if.sv
// -----------------------------------------------------------------------------
// icache_fill_ctrl_if
// Bundles the fetch-side, DRAM-side and icache-write-side signals of the fill
// controller.
//   master : the fill controller (drives DRAM request, icache write, status)
//   slave  : the surrounding fetch unit / DRAM / icache
// Signals:
//   fetch_pc, fetch_valid, icache_hit, flush    fetch side, into controller
//   fill_busy, fill_done, miss_count            status, out of controller
//   dram_req_valid/ready/addr                   DRAM read request handshake
//   dram_resp_valid/data                        DRAM response beats
//   icache_addr, icache_write_data, icache_we_aL  icache write port
// -----------------------------------------------------------------------------
interface icache_fill_ctrl_if
   import icache_fill_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int BLOCK_SIZE_BITS = ICACHE_DATA_BLOCK_SIZE,
   parameter int DRAM_BEAT_BITS  = ICACHE_DRAM_BEAT_BITS
);

   logic [ADDR_WIDTH-1:0]      fetch_pc;
   logic                       fetch_valid;
   logic                       icache_hit;
   logic                       flush;
   logic                       fill_busy;
   logic                       fill_done;
   logic                       dram_req_valid;
   logic                       dram_req_ready;
   logic [ADDR_WIDTH-1:0]      dram_req_addr;
   logic                       dram_resp_valid;
   logic [DRAM_BEAT_BITS-1:0]  dram_resp_data;
   logic [ADDR_WIDTH-1:0]      icache_addr;
   logic [BLOCK_SIZE_BITS-1:0] icache_write_data;
   logic                       icache_we_aL;
   logic [31:0]                miss_count;

   modport master (
      input  fetch_pc, fetch_valid, icache_hit, flush,
      input  dram_req_ready, dram_resp_valid, dram_resp_data,
      output fill_busy, fill_done, miss_count,
      output dram_req_valid, dram_req_addr,
      output icache_addr, icache_write_data, icache_we_aL
   );

   modport slave (
      output fetch_pc, fetch_valid, icache_hit, flush,
      output dram_req_ready, dram_resp_valid, dram_resp_data,
      input  fill_busy, fill_done, miss_count,
      input  dram_req_valid, dram_req_addr,
      input  icache_addr, icache_write_data, icache_we_aL
   );

endinterface

// File: rtl/icache_fill_ctrl_fill_beat_buffer.sv
// -----------------------------------------------------------------------------
// fill_beat_buffer
// NUM_BEATS x DRAM_BEAT_BITS assembly register for one icache block. Beat i
// lands in block bits [i*DRAM_BEAT_BITS +: DRAM_BEAT_BITS] (beat 0 = LSBs).
// Ports:
//   clk, rst_aL   clock, asynchronous active-low reset
//   i_clr         clear the whole block (start of a new fill)
//   i_wr_en       store i_wr_data into beat slot i_wr_idx
//   i_wr_idx      beat slot index
//   i_wr_data     one DRAM response beat
//   o_block       assembled block
// -----------------------------------------------------------------------------
module fill_beat_buffer #(
   parameter int DRAM_BEAT_BITS = 32,
   parameter int NUM_BEATS      = 2,
   parameter int IDX_W          = 1
) (
   input  logic                                clk,
   input  logic                                rst_aL,
   input  logic                                i_clr,
   input  logic                                i_wr_en,
   input  logic [IDX_W-1:0]                    i_wr_idx,
   input  logic [DRAM_BEAT_BITS-1:0]           i_wr_data,
   output logic [NUM_BEATS*DRAM_BEAT_BITS-1:0] o_block
);

   // Packed 2-D array: flattening it puts beat 0 in the LSBs.
   logic [NUM_BEATS-1:0][DRAM_BEAT_BITS-1:0] r_beats;

   // NOTE: this storage is reset because the block value is observable on the
   // icache data bus straight out of reset; a plain RAM would not need it.
   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         r_beats <= '0;
      end else if (i_clr) begin
         r_beats <= '0;
      end else if (i_wr_en) begin
         r_beats[i_wr_idx] <= i_wr_data;
      end
   end

   assign o_block = r_beats;

endmodule

// File: rtl/icache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_fill_ctrl
// Instruction-cache miss handler. On a fetch miss it issues one block-aligned
// DRAM read, gathers NUM_BEATS response beats into a block, writes that block
// into the icache in a single cycle (active-low enable) and then pulses
// fill_done so fetch can replay. A flush cancels the fill; beats already
// requested from DRAM are drained without being stored.
// Ports:
//   clk      system clock, rising edge
//   rst_aL   asynchronous active-low reset
//   bus      icache_fill_ctrl_if.master (fetch, DRAM and icache-write signals)
// -----------------------------------------------------------------------------
module icache_fill_ctrl
   import icache_fill_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int BLOCK_SIZE_BITS = ICACHE_DATA_BLOCK_SIZE,
   parameter int DRAM_BEAT_BITS  = ICACHE_DRAM_BEAT_BITS,
   parameter int NUM_BEATS       = BLOCK_SIZE_BITS / DRAM_BEAT_BITS
) (
   input  logic                clk,
   input  logic                rst_aL,
   icache_fill_ctrl_if.master  bus
);

   localparam int OFFSET_BITS = $clog2(BLOCK_SIZE_BITS / 8);
   localparam int CNT_W       = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

   fill_state_e           r_state;
   fill_state_e           w_state_nxt;
   logic [CNT_W-1:0]      r_beat_cnt;
   logic [ADDR_WIDTH-1:0] r_fill_addr;
   logic [31:0]           r_miss_count;

   logic                  w_start_fill;
   logic                  w_beat_store;
   logic                  w_beat_adv;
   logic                  w_beat_clr;
   logic                  w_last_beat;
   logic [ADDR_WIDTH-1:0] w_aligned_pc;

   assign w_aligned_pc = {bus.fetch_pc[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   assign w_last_beat  = (r_beat_cnt == LAST_BEAT);

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_start_fill = 1'b0;
      w_beat_store = 1'b0;
      w_beat_adv   = 1'b0;
      w_beat_clr   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (bus.fetch_valid && !bus.icache_hit && !bus.flush) begin
               w_start_fill = 1'b1;
               w_state_nxt  = ST_REQ;
            end
         end
         ST_REQ: begin
            // An accepted request must be drained even if flushed in the same
            // cycle; an unaccepted one simply never happened.
            if (bus.dram_req_ready) begin
               w_state_nxt = bus.flush ? ST_DRAIN : ST_WAIT;
            end else if (bus.flush) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (bus.dram_resp_valid) begin
               // A beat coinciding with flush is counted but not stored.
               w_beat_store = !bus.flush;
               if (w_last_beat) begin
                  w_beat_clr  = 1'b1;
                  w_state_nxt = bus.flush ? ST_IDLE : ST_WRITE;
               end else begin
                  w_beat_adv  = 1'b1;
                  w_state_nxt = bus.flush ? ST_DRAIN : ST_WAIT;
               end
            end else if (bus.flush) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (bus.dram_resp_valid) begin
               if (w_last_beat) begin
                  w_beat_clr  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_beat_adv  = 1'b1;
               end
            end
         end
         ST_WRITE: begin
            // The block is complete, so the write this cycle stands; a flush
            // only suppresses the replay notification.
            w_state_nxt = bus.flush ? ST_IDLE : ST_RESUME;
         end
         ST_RESUME: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         r_beat_cnt   <= '0;
         r_fill_addr  <= '0;
         r_miss_count <= '0;
      end else begin
         if (w_start_fill) begin
            r_fill_addr  <= w_aligned_pc;
            r_miss_count <= sat_inc32(r_miss_count);
         end
         if (w_start_fill || w_beat_clr) begin
            r_beat_cnt <= '0;
         end else if (w_beat_adv) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
         end
      end
   end

   fill_beat_buffer #(
      .DRAM_BEAT_BITS (DRAM_BEAT_BITS),
      .NUM_BEATS      (NUM_BEATS),
      .IDX_W          (CNT_W)
   ) u_buffer (
      .clk       (clk),
      .rst_aL    (rst_aL),
      .i_clr     (w_start_fill),
      .i_wr_en   (w_beat_store),
      .i_wr_idx  (r_beat_cnt),
      .i_wr_data (bus.dram_resp_data),
      .o_block   (bus.icache_write_data)
   );

   // Outputs decode directly from the state register so an asynchronous
   // reset returns them to idle values immediately.
   assign bus.fill_busy      = (r_state != ST_IDLE);
   assign bus.fill_done      = (r_state == ST_RESUME) && !bus.flush;
   assign bus.dram_req_valid = (r_state == ST_REQ);
   assign bus.dram_req_addr  = r_fill_addr;
   assign bus.icache_addr    = (r_state == ST_WRITE) ? r_fill_addr : bus.fetch_pc;
   assign bus.icache_we_aL   = (r_state != ST_WRITE);
   assign bus.miss_count     = r_miss_count;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_fill_ctrl
// Directed bench for icache_fill_ctrl. A transaction-level model (fill
// outstanding / request pending / discarding / write due / done due) predicts
// every output; a compare process checks it each falling edge. Hand-computed
// literals pin the model on the key cycles of each scenario.
// -----------------------------------------------------------------------------
module tb_icache_fill_ctrl;
   import icache_fill_ctrl_pkg::*;

   localparam int AW = 32;
   localparam int BB = 64;
   localparam int DB = 32;
   localparam int NB = BB / DB;

   logic clk    = 1'b0;
   logic rst_aL = 1'b0;
   always #5 clk = ~clk;

   icache_fill_ctrl_if #(.ADDR_WIDTH(AW), .BLOCK_SIZE_BITS(BB), .DRAM_BEAT_BITS(DB)) bus ();

   icache_fill_ctrl #(
      .ADDR_WIDTH      (AW),
      .BLOCK_SIZE_BITS (BB),
      .DRAM_BEAT_BITS  (DB),
      .NUM_BEATS       (NB)
   ) dut (
      .clk    (clk),
      .rst_aL (rst_aL),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc_cnt  = 0;
   int miss_cyc = 0;
   int last_done_cyc = -1;
   int n_writes = 0;
   int n_dones  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   bit              m_active, m_req_pending, m_discard, m_write_now, m_done_now;
   int              m_beats;
   logic [AW-1:0]   m_fill_addr;
   logic [31:0]     m_miss;
   logic [DB-1:0]   m_data [NB];

   always @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         m_active <= 0; m_req_pending <= 0; m_discard <= 0;
         m_write_now <= 0; m_done_now <= 0; m_beats <= 0;
         m_fill_addr <= '0; m_miss <= '0;
         for (int i = 0; i < NB; i++) m_data[i] <= '0;
      end else if (!m_active) begin
         if (bus.fetch_valid && !bus.icache_hit && !bus.flush) begin
            m_active <= 1; m_req_pending <= 1; m_discard <= 0; m_beats <= 0;
            m_fill_addr <= bus.fetch_pc & ~32'h7;
            m_miss <= (m_miss == 32'hFFFF_FFFF) ? m_miss : m_miss + 1;
            for (int i = 0; i < NB; i++) m_data[i] <= '0;
         end
      end else if (m_write_now) begin
         m_write_now <= 0;
         if (bus.flush) m_active <= 0;
         else m_done_now <= 1;
      end else if (m_done_now) begin
         m_done_now <= 0;
         m_active <= 0;
      end else if (m_req_pending) begin
         if (bus.dram_req_ready) begin
            m_req_pending <= 0;
            if (bus.flush) m_discard <= 1;
         end else if (bus.flush) begin
            m_active <= 0;
         end
      end else begin
         if (bus.dram_resp_valid) begin
            if (!m_discard && !bus.flush) m_data[m_beats] <= bus.dram_resp_data;
            if (m_beats == NB - 1) begin
               m_beats <= 0;
               if (m_discard || bus.flush) m_active <= 0;
               else m_write_now <= 1;
            end else begin
               m_beats <= m_beats + 1;
               if (bus.flush) m_discard <= 1;
            end
         end else if (bus.flush) begin
            m_discard <= 1;
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      logic [BB-1:0] exp_blk;
      check("busy",        64'(bus.fill_busy),      64'(m_active));
      check("req_valid",   64'(bus.dram_req_valid), 64'(m_active && m_req_pending));
      check("req_addr",    64'(bus.dram_req_addr),  64'(m_fill_addr));
      check("we_aL",       64'(bus.icache_we_aL),   64'(!m_write_now));
      check("icache_addr", 64'(bus.icache_addr),    64'(m_write_now ? m_fill_addr : bus.fetch_pc));
      check("fill_done",   64'(bus.fill_done),      64'(m_done_now && !bus.flush));
      check("miss_count",  64'(bus.miss_count),     64'(m_miss));
      if (m_write_now) begin
         for (int i = 0; i < NB; i++) exp_blk[i*DB +: DB] = m_data[i];
         check("wdata", 64'(bus.icache_write_data), 64'(exp_blk));
      end
      if (bus.icache_we_aL === 1'b0) n_writes++;
      if (bus.fill_done === 1'b1) begin
         n_dones++;
         last_done_cyc = cyc_cnt;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
      cyc_cnt++;
   endtask

   task automatic miss(input logic [AW-1:0] pc);
      bus.fetch_pc    = pc;
      bus.fetch_valid = 1'b1;
      bus.icache_hit  = 1'b0;
      miss_cyc        = cyc_cnt;
      tick();
      bus.fetch_valid = 1'b0;
   endtask

   task automatic beat(input logic [DB-1:0] d);
      bus.dram_resp_valid = 1'b1;
      bus.dram_resp_data  = d;
      tick();
      bus.dram_resp_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int w0, d0;
      bus.fetch_pc = '0; bus.fetch_valid = 1'b0; bus.icache_hit = 1'b0;
      bus.flush = 1'b0; bus.dram_req_ready = 1'b0;
      bus.dram_resp_valid = 1'b0; bus.dram_resp_data = '0;

      // Reset for two cycles.
      rst_aL = 1'b0;
      tick(); tick();
      check("rst_busy",  64'(bus.fill_busy),    64'd0);
      check("rst_we",    64'(bus.icache_we_aL), 64'd1);
      check("rst_miss",  64'(bus.miss_count),   64'd0);
      check("rst_wdata", 64'(bus.icache_write_data), 64'd0);
      rst_aL = 1'b1;
      tick();

      // 1. Basic fill.
      bus.dram_req_ready = 1'b1;
      miss(32'h0000_0104);
      check("t1_req_valid", 64'(bus.dram_req_valid), 64'd1);
      check("t1_req_addr",  64'(bus.dram_req_addr),  64'h100);
      tick();
      check("t1_req_drop",  64'(bus.dram_req_valid), 64'd0);
      beat(32'h7654_3210);
      beat(32'hFEDC_BA98);
      check("t1_we",     64'(bus.icache_we_aL),      64'd0);
      check("t1_iaddr",  64'(bus.icache_addr),       64'h100);
      check("t1_wdata",  64'(bus.icache_write_data), 64'hFEDC_BA98_7654_3210);
      tick();
      check("t1_done",   64'(bus.fill_done),  64'd1);
      check("t1_miss",   64'(bus.miss_count), 64'd1);
      tick();
      check("t1_lat",    64'(last_done_cyc - miss_cyc), 64'd5);
      check("t1_idle",   64'(bus.fill_busy), 64'd0);

      // 2. Request backpressure for 3 cycles.
      bus.dram_req_ready = 1'b0;
      miss(32'h0000_0100);
      for (int i = 0; i < 3; i++) begin
         check("t2_hold_valid", 64'(bus.dram_req_valid), 64'd1);
         check("t2_hold_addr",  64'(bus.dram_req_addr),  64'h100);
         tick();
      end
      check("t2_hold_valid", 64'(bus.dram_req_valid), 64'd1);
      check("t2_hold_addr",  64'(bus.dram_req_addr),  64'h100);
      bus.dram_req_ready = 1'b1;
      tick();
      beat(32'h1111_1111);
      beat(32'h2222_2222);
      check("t2_wdata", 64'(bus.icache_write_data), 64'h2222_2222_1111_1111);
      tick(); tick();
      check("t2_lat", 64'(last_done_cyc - miss_cyc), 64'd8);

      // 3. Flush in WAIT after beat 0; a second flush in DRAIN is ignored.
      w0 = n_writes; d0 = n_dones;
      miss(32'h0000_0300);
      tick();
      beat(32'hAAAA_AAAA);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("t3_draining", 64'(bus.fill_busy), 64'd1);
      bus.flush = 1'b1;
      beat(32'hBBBB_BBBB);
      bus.flush = 1'b0;
      check("t3_busy_drop", 64'(bus.fill_busy), 64'd0);
      tick();
      check("t3_no_write", 64'(n_writes - w0), 64'd0);
      check("t3_no_done",  64'(n_dones - d0),  64'd0);

      // 4. Flush in REQ without ready, then a fresh miss.
      bus.dram_req_ready = 1'b0;
      miss(32'h0000_0400);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("t4_req_gone", 64'(bus.dram_req_valid), 64'd0);
      check("t4_idle",     64'(bus.fill_busy),      64'd0);
      bus.dram_req_ready = 1'b1;
      miss(32'h0000_0208);
      check("t4_req_addr", 64'(bus.dram_req_addr), 64'h208);
      check("t4_miss",     64'(bus.miss_count),    64'd5);
      tick();
      beat(32'h0000_0001);
      beat(32'h0000_0002);
      tick(); tick();

      // 5. Gaps between beats, then reset during WAIT.
      miss(32'h0000_0500);
      tick();
      beat(32'hCAFE_0000);
      tick(); tick();
      beat(32'hBEEF_0001);
      check("t5_we",    64'(bus.icache_we_aL),      64'd0);
      check("t5_wdata", 64'(bus.icache_write_data), 64'hBEEF_0001_CAFE_0000);
      tick(); tick();
      miss(32'h0000_0508);
      tick();
      beat(32'h1234_5678);
      rst_aL = 1'b0;
      #1;
      check("t5_rst_busy",  64'(bus.fill_busy),      64'd0);
      check("t5_rst_we",    64'(bus.icache_we_aL),   64'd1);
      check("t5_rst_req",   64'(bus.dram_req_valid), 64'd0);
      check("t5_rst_miss",  64'(bus.miss_count),     64'd0);
      check("t5_rst_wdata", 64'(bus.icache_write_data), 64'd0);
      tick();
      w0 = n_writes;
      rst_aL = 1'b1;
      beat(32'h9ABC_DEF0);
      check("t5_stray_busy", 64'(bus.fill_busy), 64'd0);
      tick();
      check("t5_stray_nowr", 64'(n_writes - w0), 64'd0);

      // 6. Flush during WRITE: write happens, no fill_done.
      w0 = n_writes; d0 = n_dones;
      miss(32'h0000_0600);
      tick();
      beat(32'h5555_5555);
      beat(32'h6666_6666);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("t6_idle",  64'(bus.fill_busy), 64'd0);
      tick();
      check("t6_write", 64'(n_writes - w0), 64'd1);
      check("t6_nodone", 64'(n_dones - d0), 64'd0);
      check("t6_miss",  64'(bus.miss_count), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
- Miss handler that sits directly upstream of the instruction cache's write port.
- On a fetch miss it issues a block-aligned DRAM read and collects the response beats into a full cache block.
- It performs a single write into the icache (active-low write enable), then pulses fill_done so fetch can replay the access.
- It supports flush/redirect cancellation and DRAM request backpressure.

Parameters:
- ADDR_WIDTH, 32, fetch/DRAM address width
- BLOCK_SIZE_BITS, `ICACHE_DATA_BLOCK_SIZE (64), icache block and write width
- DRAM_BEAT_BITS, 32, width of one DRAM response beat
- NUM_BEATS, BLOCK_SIZE_BITS/DRAM_BEAT_BITS (2), beats per fill; must be a power of two and at least 1

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_aL  in  1  asynchronous, active-low reset
- fetch_pc  in  ADDR_WIDTH  current fetch address
- fetch_valid  in  1  fetch_pc is a real access this cycle
- icache_hit  in  1  cache_hit from the icache for fetch_pc
- flush  in  1  redirect; cancels any fill in progress
- fill_busy  out  1  high whenever state != IDLE; fetch stalls
- fill_done  out  1  one-cycle pulse; the filled block is now readable
- dram_req_valid  out  1  read request valid
- dram_req_ready  in  1  DRAM accepts the request
- dram_req_addr  out  ADDR_WIDTH  block-aligned request address
- dram_resp_valid  in  1  response beat valid; no backpressure
- dram_resp_data  in  DRAM_BEAT_BITS  response beat
- icache_addr  out  ADDR_WIDTH  address driven to the icache
- icache_write_data  out  BLOCK_SIZE_BITS  assembled block
- icache_we_aL  out  1  icache write enable, active low
- miss_count  out  32  saturating count of fills started

Behaviour:
- Reset (asynchronous, rst_aL=0):
  - state=IDLE, beat_cnt=0, fill_addr=0, buffer=0, miss_count=0.
  - icache_we_aL=1; dram_req_valid=0; fill_done=0; fill_busy=0.
  - Reset mid-fill abandons the fill. No write occurs. Any beats that arrive after reset are ignored.
- Alignment: fill_addr = fetch_pc with the low log2(BLOCK_SIZE_BITS/8) bits cleared. dram_req_addr = fill_addr.
- icache_addr is combinational: fill_addr in WRITE, otherwise fetch_pc.
- IDLE:
  - Condition: fetch_valid && !icache_hit && !flush.
  - Action: latch fill_addr, clear beat_cnt, increment miss_count (saturating at 0xFFFFFFFF), go to REQ.
  - All other cycles stay in IDLE.
- REQ:
  - dram_req_valid=1. dram_req_addr is held stable until the handshake.
  - On dram_req_ready: go to WAIT.
  - On flush without ready: go to IDLE; no request is considered issued.
  - On flush together with ready: the handshake counts; go to DRAIN.
- WAIT:
  - Each dram_resp_valid writes beat beat_cnt into buffer bits [beat_cnt*DRAM_BEAT_BITS +: DRAM_BEAT_BITS] (beat 0 is the LSBs), then increments beat_cnt.
  - On the last beat (beat_cnt==NUM_BEATS-1 with valid): go to WRITE.
  - On flush: go to DRAIN. A beat arriving in the same cycle as flush is counted, not stored.
- DRAIN:
  - Counts the remaining beats without storing them. Does not write the icache.
  - When the last beat arrives: go to IDLE. fill_done is not asserted.
  - Further flushes are ignored.
- WRITE:
  - Exactly one cycle: icache_we_aL=0, icache_write_data=buffer.
  - Next state is RESUME, or IDLE if flush is asserted. The write still happens because the data is complete.
- RESUME:
  - fill_done=1 for one cycle, unless flush is asserted. Go to IDLE.
  - The fetch re-read in the following cycle must hit.
- dram_resp_valid in IDLE, REQ or RESUME is a protocol error and is ignored. No state change.
- Latency: a miss with immediate ready and back-to-back beats runs IDLE→REQ(1)→WAIT(NUM_BEATS)→WRITE(1)→RESUME(1). fill_done asserts NUM_BEATS+3 cycles after the miss cycle.
- Gaps between beats are allowed. beat_cnt wraps to 0 only on leaving WAIT or DRAIN.

Decomposition:
- Add to misc/global_defs.vh:
  - state encodings (IDLE, REQ, WAIT, DRAIN, WRITE, RESUME; 3 bits)
  - `ICACHE_DRAM_BEAT_BITS
  - `ICACHE_FILL_BEATS
- Sub-module fill_beat_buffer: NUM_BEATS×DRAM_BEAT_BITS register with indexed beat write and clear, driving icache_write_data.
- FSM, counters and muxing live in icache_fill_ctrl.

Test Plan:
1. Basic fill:
   - Stimulus: rst_aL low for 2 cycles, then high. fetch_pc=0x00000104, fetch_valid=1, icache_hit=0, dram_req_ready=1. Beats 0x76543210 then 0xFEDCBA98 on consecutive cycles.
   - Required: dram_req_addr=0x00000100 for one cycle. icache_we_aL=0 for exactly one cycle with icache_addr=0x00000100 and icache_write_data=0xFEDCBA98_76543210. fill_done pulses the next cycle. miss_count=1.
2. Backpressure:
   - Stimulus: dram_req_ready held low for 3 cycles after the miss.
   - Required: dram_req_valid=1 and dram_req_addr=0x00000100 stable for all 4 cycles. fill_done arrives 3 cycles later than in test 1.
3. Flush in WAIT:
   - Stimulus: flush after beat 0, then beat 1 arrives.
   - Required: icache_we_aL stays 1, fill_done never pulses, state returns to IDLE after beat 1, fill_busy drops the following cycle.
4. Flush in REQ:
   - Stimulus: flush while dram_req_ready=0.
   - Required: IDLE next cycle, dram_req_valid=0. A later miss at 0x00000208 requests 0x00000208, and miss_count counts both.
5. Beat gaps and reset mid-fill:
   - Stimulus: beats separated by 2 idle cycles, then assert rst_aL=0 during WAIT.
   - Required: buffer assembles the beats correctly across the gaps. On reset, all outputs immediately return to their reset values (icache_we_aL=1). A stray beat after reset causes no write.
